// File: rtl/exponent_pkg.sv
// ---------------------------------------------------------------------------
// exponent_pkg
// Shared defaults and result record for the exponent-difference pipeline.
//   EW_DEF        default exponent width
//   MAX_SHIFT_DEF default largest meaningful alignment shift
//   SW_DEF        shift width matching MAX_SHIFT_DEF
//   exp_res_t     result record at the default widths
// ---------------------------------------------------------------------------
package exponent_pkg;

  localparam int EW_DEF        = 8;
  localparam int MAX_SHIFT_DEF = 16;
  localparam int SW_DEF        = $clog2(MAX_SHIFT_DEF + 1);

  typedef struct packed {
    logic [EW_DEF-1:0] er;
    logic              greater;
    logic              equal;
    logic [EW_DEF-1:0] diff;
    logic [SW_DEF-1:0] shift;
    logic              shifted_out;
    logic              zero_res;
  } exp_res_t;

endpackage

// File: rtl/exp_abs_sub.sv
// ---------------------------------------------------------------------------
// exp_abs_sub
// Combinational magnitude and larger-operand selection from a registered
// raw difference.
//   dr        EW+1-bit e1 - e2; MSB is the borrow (e1 < e2)
//   e1, e2    operand exponents
//   z1, z2    operand-is-zero flags
//   er        selected (larger) exponent
//   mag       |e1 - e2|, forced to 0 when either operand is zero
//   greater   operand 1 selected (ties and both-zero included)
//   equal     e1 == e2 with both operands non-zero
// ---------------------------------------------------------------------------
module exp_abs_sub #(
  parameter int EW = 8
) (
  input  logic [EW:0]   dr,
  input  logic [EW-1:0] e1,
  input  logic [EW-1:0] e2,
  input  logic          z1,
  input  logic          z2,
  output logic [EW-1:0] er,
  output logic [EW-1:0] mag,
  output logic          greater,
  output logic          equal
);

  always_comb begin
    er      = '0;
    mag     = '0;
    greater = 1'b1;
    equal   = 1'b0;
    if (z1 && z2) begin
      // both zero: defaults already describe the result
    end else if (z1) begin
      er      = e2;
      greater = 1'b0;
    end else if (z2) begin
      er = e1;
    end else if (dr[EW]) begin
      // borrow: low EW bits hold 2^EW - |d|, negation recovers |d| without wrap
      er      = e2;
      greater = 1'b0;
      mag     = -dr[EW-1:0];
    end else begin
      er    = e1;
      mag   = dr[EW-1:0];
      equal = (dr[EW-1:0] == '0);
    end
  end

endmodule

// File: rtl/exponent_diff_pipe.sv
// ---------------------------------------------------------------------------
// exponent_diff_pipe
// Two-stage valid/ready pipeline computing exponent alignment information for
// a floating-point add: larger exponent, |e1 - e2|, saturated shift and flags.
//   clk, rst_n           clock, async active-low reset
//   in_valid / in_ready  operand pair handshake
//   e1, e2, z1, z2       biased exponents and zero flags
//   out_valid/out_ready  result handshake
//   er, greater, equal, diff, shift, shifted_out, zero_res   result fields
// S1 holds operands plus the raw EW+1-bit difference; S2 holds the result.
// ---------------------------------------------------------------------------
module exponent_diff_pipe
  import exponent_pkg::*;
#(
  parameter  int EW        = EW_DEF,
  parameter  int MAX_SHIFT = MAX_SHIFT_DEF,
  localparam int SW        = $clog2(MAX_SHIFT + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [EW-1:0] e1,
  input  logic [EW-1:0] e2,
  input  logic          z1,
  input  logic          z2,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [EW-1:0] er,
  output logic          greater,
  output logic          equal,
  output logic [EW-1:0] diff,
  output logic [SW-1:0] shift,
  output logic          shifted_out,
  output logic          zero_res
);

  localparam logic [EW-1:0] MAX_E = EW'(MAX_SHIFT);
  localparam logic [SW-1:0] MAX_S = SW'(MAX_SHIFT);

  logic          run;
  logic          s1_valid;
  logic [EW-1:0] s1_e1, s1_e2;
  logic          s1_z1, s1_z2;
  logic [EW:0]   s1_dr;

  logic          s2_take, s1_adv, in_fire;
  logic [EW-1:0] c_er, c_mag;
  logic          c_greater, c_equal, c_sat;
  logic [SW-1:0] c_shift;

  assign s2_take  = !out_valid || out_ready;
  assign s1_adv   = s1_valid && s2_take;
  // run keeps in_ready low until the first edge after reset release
  assign in_ready = run && (!s1_valid || s1_adv);
  assign in_fire  = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run <= 1'b0;
    else        run <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_e1    <= '0;
      s1_e2    <= '0;
      s1_z1    <= 1'b0;
      s1_z2    <= 1'b0;
      s1_dr    <= '0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
      s1_e1    <= e1;
      s1_e2    <= e2;
      s1_z1    <= z1;
      s1_z2    <= z2;
      s1_dr    <= {1'b0, e1} - {1'b0, e2};
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  exp_abs_sub #(.EW(EW)) u_abs (
    .dr      (s1_dr),
    .e1      (s1_e1),
    .e2      (s1_e2),
    .z1      (s1_z1),
    .z2      (s1_z2),
    .er      (c_er),
    .mag     (c_mag),
    .greater (c_greater),
    .equal   (c_equal)
  );

  assign c_sat   = (c_mag > MAX_E);
  assign c_shift = c_sat ? MAX_S : c_mag[SW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      er          <= '0;
      greater     <= 1'b0;
      equal       <= 1'b0;
      diff        <= '0;
      shift       <= '0;
      shifted_out <= 1'b0;
      zero_res    <= 1'b0;
    end else if (s2_take) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        er          <= c_er;
        greater     <= c_greater;
        equal       <= c_equal;
        diff        <= c_mag;
        shift       <= c_shift;
        shifted_out <= c_sat;
        zero_res    <= s1_z1 && s1_z2;
      end
    end
  end

endmodule

// File: tb/tb_exponent_diff_pipe.sv
module tb_exponent_diff_pipe;
  import exponent_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       z1 = 1'b0, z2 = 1'b0;
  logic [7:0] e1 = '0, e2 = '0;
  logic       in_ready, out_valid;
  logic [7:0] er, diff;
  logic       greater, equal, shifted_out, zero_res;
  logic [4:0] shift;
  exp_res_t   obs;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  exponent_diff_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .e1(e1), .e2(e2), .z1(z1), .z2(z2),
    .out_valid(out_valid), .out_ready(out_ready),
    .er(er), .greater(greater), .equal(equal), .diff(diff),
    .shift(shift), .shifted_out(shifted_out), .zero_res(zero_res)
  );

  assign obs = {er, greater, equal, diff, shift, shifted_out, zero_res};

  function automatic exp_res_t mk(input logic [7:0] er_v, input logic g, input logic eq,
                                  input logic [7:0] d, input logic [4:0] s,
                                  input logic so, input logic zr);
    return {er_v, g, eq, d, s, so, zr};
  endfunction

  function automatic exp_res_t model(input logic [7:0] a, input logic [7:0] b,
                                     input logic za, input logic zb);
    exp_res_t r;
    int d;
    r = '0;
    d = 0;
    if (za && zb) begin
      r.greater = 1'b1;
      r.zero_res = 1'b1;
    end else if (za) begin
      r.er = b;
    end else if (zb) begin
      r.er = a;
      r.greater = 1'b1;
    end else begin
      if (a >= b) begin
        r.er = a; r.greater = 1'b1; d = int'(a) - int'(b);
      end else begin
        r.er = b; d = int'(b) - int'(a);
      end
      r.equal = (a == b);
      r.diff = 8'(d);
      r.shift = (d > 16) ? 5'd16 : 5'(d);
      r.shifted_out = (d > 16);
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                       input logic za, input logic zb);
    in_valid = v; e1 = a; e2 = b; z1 = za; z2 = zb;
  endtask

  // single pair with out_ready high; returns at the negedge where it is on the output
  task automatic send_one(input logic [7:0] a, input logic [7:0] b,
                          input logic za, input logic zb);
    step();
    out_ready = 1'b1;
    drive(1'b1, a, b, za, zb);
    step();
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    checks++; if (obs !== exp_res_t'('0)) begin errors++; $display("FAIL reset_outputs: got %h want 0", obs); end
    #2 rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ready_before_edge: got %b want 0", in_ready); end
    step();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ready_after_edge: got %b want 1", in_ready); end
  endtask

  task automatic test_basic();
    exp_res_t x;
    x = mk(8'h50, 1, 0, 8'h08, 5'd8, 0, 0);
    out_ready = 1'b1;
    drive(1'b1, 8'h50, 8'h48, 1'b0, 1'b0);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready: got %b want 1", in_ready); end
    step();
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_latency_early: got %b want 0", out_valid); end
    step();
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid: got %b want 1", out_valid); end
    checks++; if (obs !== x) begin errors++; $display("FAIL basic_result: got %h want %h", obs, x); end
    step();
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drained: got %b want 0", out_valid); end
  endtask

  task automatic test_saturate();
    exp_res_t x;
    x = mk(8'h40, 0, 0, 8'h30, 5'd16, 1, 0);
    send_one(8'h10, 8'h40, 1'b0, 1'b0);
    checks++; if (out_valid !== 1'b1 || obs !== x) begin errors++; $display("FAIL saturate: got v=%b %h want %h", out_valid, obs, x); end
  endtask

  task automatic test_zero();
    exp_res_t x;
    x = mk(8'h33, 0, 0, 8'h00, 5'd0, 0, 0);
    send_one(8'h00, 8'h33, 1'b1, 1'b0);
    checks++; if (out_valid !== 1'b1 || obs !== x) begin errors++; $display("FAIL z1_only: got v=%b %h want %h", out_valid, obs, x); end
    x = mk(8'h00, 1, 0, 8'h00, 5'd0, 0, 1);
    send_one(8'h00, 8'h33, 1'b1, 1'b1);
    checks++; if (out_valid !== 1'b1 || obs !== x) begin errors++; $display("FAIL both_zero: got v=%b %h want %h", out_valid, obs, x); end
    x = mk(8'h44, 1, 0, 8'h00, 5'd0, 0, 0);
    send_one(8'h44, 8'h99, 1'b0, 1'b1);
    checks++; if (out_valid !== 1'b1 || obs !== x) begin errors++; $display("FAIL z2_only: got v=%b %h want %h", out_valid, obs, x); end
  endtask

  task automatic test_boundary();
    exp_res_t x;
    x = mk(8'h20, 1, 0, 8'h10, 5'd16, 0, 0);
    send_one(8'h20, 8'h10, 1'b0, 1'b0);
    checks++; if (obs !== x) begin errors++; $display("FAIL diff_eq_max: got %h want %h", obs, x); end
    x = mk(8'h22, 0, 0, 8'h11, 5'd16, 1, 0);
    send_one(8'h11, 8'h22, 1'b0, 1'b0);
    checks++; if (obs !== x) begin errors++; $display("FAIL diff_max_plus1: got %h want %h", obs, x); end
    x = mk(8'hFF, 0, 0, 8'hFF, 5'd16, 1, 0);
    send_one(8'h00, 8'hFF, 1'b0, 1'b0);
    checks++; if (obs !== x) begin errors++; $display("FAIL extreme_borrow: got %h want %h", obs, x); end
  endtask

  task automatic test_back_to_back();
    exp_res_t xa, xb, xc;
    xa = mk(8'h20, 1, 1, 8'h00, 5'd0, 0, 0);
    xb = mk(8'hFF, 1, 0, 8'hFF, 5'd16, 1, 0);
    xc = mk(8'h02, 0, 0, 8'h01, 5'd1, 0, 0);
    step();
    out_ready = 1'b1;
    drive(1'b1, 8'h20, 8'h20, 1'b0, 1'b0);
    step();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_b: got %b want 1", in_ready); end
    drive(1'b1, 8'hFF, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_early: got %b want 0", out_valid); end
    step();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_c: got %b want 1", in_ready); end
    drive(1'b1, 8'h01, 8'h02, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || obs !== xa) begin errors++; $display("FAIL b2b_first: got v=%b %h want %h", out_valid, obs, xa); end
    step();
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || obs !== xb) begin errors++; $display("FAIL b2b_second: got v=%b %h want %h", out_valid, obs, xb); end
    step();
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || obs !== xc) begin errors++; $display("FAIL b2b_third: got v=%b %h want %h", out_valid, obs, xc); end
    step();
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained: got %b want 0", out_valid); end
  endtask

  task automatic test_random_stall();
    exp_res_t q[$];
    exp_res_t x, prev_obs;
    bit prev_stall = 0;
    bit pend = 0;
    int sent = 0, recv = 0, cyc = 0;
    prev_obs = '0;
    step();
    while (recv < 1000 && cyc < 20000) begin
      if (!pend && sent < 1000) begin
        drive(1'b1, 8'($urandom), 8'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
        pend = 1;
      end else if (!pend) begin
        in_valid = 1'b0;
      end
      out_ready = ($urandom_range(0, 99) >= 35);
      @(negedge clk);
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || obs !== prev_obs) begin errors++; $display("FAIL stall_hold: got v=%b %h want 1 %h", out_valid, obs, prev_obs); end
      end
      if (!in_ready) begin
        checks++;
        if (!(out_valid && !out_ready)) begin errors++; $display("FAIL spurious_backpressure: got out_valid=%b out_ready=%b want 1 0", out_valid, out_ready); end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL random_extra_output: got %h want none", obs);
        end else begin
          x = q.pop_front();
          if (obs !== x) begin errors++; $display("FAIL random_result #%0d: got %h want %h", recv, obs, x); end
        end
        recv++;
      end
      if (in_valid && in_ready) begin
        q.push_back(model(e1, e2, z1, z2));
        pend = 0;
        sent++;
      end
      prev_stall = out_valid && !out_ready;
      prev_obs = obs;
      cyc++;
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (recv != 1000 || q.size() != 0) begin errors++; $display("FAIL random_count: got recv=%0d left=%0d want 1000 0", recv, q.size()); end
  endtask

  task automatic test_reset_midflight();
    exp_res_t x;
    x = mk(8'h07, 0, 0, 8'h02, 5'd2, 0, 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    drive(1'b1, 8'h30, 8'h31, 1'b0, 1'b0);
    step();
    drive(1'b1, 8'h40, 8'h3F, 1'b0, 1'b0);
    step();
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL midflight_full: got v=%b rdy=%b want 1 0", out_valid, in_ready); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || obs !== exp_res_t'('0)) begin errors++; $display("FAIL async_reset: got v=%b %h want 0 0", out_valid, obs); end
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stale_output %0d: got %b want 0", i, out_valid); end
    end
    send_one(8'h05, 8'h07, 1'b0, 1'b0);
    checks++; if (out_valid !== 1'b1 || obs !== x) begin errors++; $display("FAIL post_reset_pair: got v=%b %h want %h", out_valid, obs, x); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturate();
    test_zero();
    test_boundary();
    test_back_to_back();
    test_random_stall();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
